// File: rtl/mdu_iter_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit: operand handshake, result handshake, abort and status.
interface mdu_iter_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output in_valid, funct3, rs1, rs2, flush, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, funct3, rs1, rs2, flush, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide share one 2*XLEN working register. Operands are converted
// to magnitudes on acceptance and the sign is restored on the DONE-entry edge.
// The result is presented one cycle after DONE is entered, so a normal op shows
// out_valid XLEN+1 edges after acceptance and a special case after one edge.
module mdu_iter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input logic        clk,
   input logic        rst_n,
   mdu_iter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};
   localparam logic [XLEN-1:0]  ONES_X   = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);

   // rs1 is treated as signed for MULH, MULHSU, DIV, REM
   function automatic logic rs1_signed(input logic [2:0] f3);
      case (f3)
         3'b001, 3'b010, 3'b100, 3'b110: rs1_signed = 1'b1;
         default:                        rs1_signed = 1'b0;
      endcase
   endfunction

   // rs2 is treated as signed for MULH, DIV, REM
   function automatic logic rs2_signed(input logic [2:0] f3);
      case (f3)
         3'b001, 3'b100, 3'b110: rs2_signed = 1'b1;
         default:                rs2_signed = 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
      neg_x = ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
      neg_2x = ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
   endfunction

   state_t            state_r, state_s;
   logic [2:0]        f3_r, f3_s;
   logic              sa_r, sa_s, sb_r, sb_s;
   logic [XLEN-1:0]   op_r, op_s;          // multiplicand or divisor magnitude
   logic [2*XLEN-1:0] acc_r, acc_s;        // product, or {remainder, quotient}
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [XLEN-1:0]   result_r, result_s;
   logic              in_ready_r, out_valid_r, busy_r;

   logic              a_neg_s, b_neg_s;
   logic [XLEN-1:0]   a_mag_s, b_mag_s;
   logic              div_zero_s, div_ovf_s, special_s;
   logic [XLEN-1:0]   special_res_s;
   logic [XLEN:0]     mul_sum_s, div_diff_s;
   logic [2*XLEN-1:0] step_s, prod_s;
   logic [XLEN-1:0]   fixup_s;

   // Operand conditioning and special-case detection for the incoming request
   always_comb begin
      a_neg_s    = rs1_signed(bus.funct3) & bus.rs1[XLEN-1];
      b_neg_s    = rs2_signed(bus.funct3) & bus.rs2[XLEN-1];
      a_mag_s    = a_neg_s ? neg_x(bus.rs1) : bus.rs1;
      b_mag_s    = b_neg_s ? neg_x(bus.rs2) : bus.rs2;
      div_zero_s = bus.funct3[2] && (bus.rs2 == ZERO_X);
      div_ovf_s  = bus.funct3[2] && !bus.funct3[0] &&
                   (bus.rs1 == MIN_NEG) && (bus.rs2 == ONES_X);
      special_s  = div_zero_s | div_ovf_s;
      if (div_zero_s) begin
         special_res_s = bus.funct3[1] ? bus.rs1 : ONES_X;
      end else if (div_ovf_s) begin
         special_res_s = bus.funct3[1] ? ZERO_X : bus.rs1;
      end else begin
         special_res_s = ZERO_X;
      end
   end

   // One multiply or divide iteration, plus the sign fixup of that iteration's output
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                   (acc_r[0] ? {1'b0, op_r} : {(XLEN+1){1'b0}});
      div_diff_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, op_r};
      if (f3_r[2]) begin
         if (!div_diff_s[XLEN]) begin
            step_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
         end else begin
            step_s = {acc_r[2*XLEN-2:XLEN-1], acc_r[XLEN-2:0], 1'b0};
         end
      end else begin
         step_s = {mul_sum_s, acc_r[XLEN-1:1]};
      end
      prod_s = (sa_r ^ sb_r) ? neg_2x(step_s) : step_s;
      case (f3_r)
         3'b000:                 fixup_s = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fixup_s = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fixup_s = (sa_r ^ sb_r) ? neg_x(step_s[XLEN-1:0])
                                                         : step_s[XLEN-1:0];
         3'b110, 3'b111:         fixup_s = sa_r ? neg_x(step_s[2*XLEN-1:XLEN])
                                                : step_s[2*XLEN-1:XLEN];
         default:                fixup_s = ZERO_X;
      endcase
   end

   // Next-state and datapath-update decode for the IDLE/CALC/DONE sequencer
   always_comb begin
      state_s  = state_r;
      f3_s     = f3_r;
      sa_s     = sa_r;
      sb_s     = sb_r;
      op_s     = op_r;
      acc_s    = acc_r;
      cnt_s    = cnt_r;
      result_s = result_r;
      case (state_r)
         IDLE: begin
            if (bus.flush) begin
               state_s = IDLE;
            end else if (bus.in_valid) begin
               f3_s  = bus.funct3;
               sa_s  = a_neg_s;
               sb_s  = b_neg_s;
               cnt_s = CNT_LOAD;
               if (bus.funct3[2]) begin
                  op_s  = b_mag_s;
                  acc_s = {ZERO_X, a_mag_s};
               end else begin
                  op_s  = a_mag_s;
                  acc_s = {ZERO_X, b_mag_s};
               end
               if (special_s) begin
                  state_s  = DONE;
                  result_s = special_res_s;
               end else begin
                  state_s = CALC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            acc_s = step_s;
            cnt_s = cnt_r - CNT_ONE;
            if (bus.flush) begin
               state_s = IDLE;
            end else if (cnt_r == CNT_ONE) begin
               state_s  = DONE;
               result_s = fixup_s;
            end else begin
               state_s = CALC;
            end
         end
         DONE: begin
            // out_ready only counts once the result is actually presented
            if (bus.flush || (bus.out_ready && out_valid_r)) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         f3_r        <= 3'b000;
         sa_r        <= 1'b0;
         sb_r        <= 1'b0;
         op_r        <= ZERO_X;
         acc_r       <= {(2*XLEN){1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         result_r    <= ZERO_X;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         f3_r        <= f3_s;
         sa_r        <= sa_s;
         sb_r        <= sb_s;
         op_r        <= op_s;
         acc_r       <= acc_s;
         cnt_r       <= cnt_s;
         result_r    <= result_s;
         in_ready_r  <= (state_s == IDLE);
         out_valid_r <= (state_r == DONE) && (state_s == DONE);
         busy_r      <= (state_s != IDLE);
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.result    = result_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (XLEN=32): arithmetic vectors,
// special cases, latency, result hold, flush and mid-operation reset.
module tb_mdu_iter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mdu_iter_if #(.XLEN(32)) bus ();

   mdu_iter #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one op, scramble inputs after acceptance, measure latency, hold, consume
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int hold);
      int          lat;
      logic [31:0] first_res;
      bus.funct3   = f3;
      bus.rs1      = a;
      bus.rs2      = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.rs1      = ~a;
      bus.rs2      = a ^ b;
      bus.funct3   = ~f3;
      check_eq({tag, "_busy"}, {63'd0, bus.busy}, 64'd1);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_res"}, {32'd0, bus.result}, {32'd0, exp_res});
      first_res = bus.result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq({tag, "_hold_res"}, {32'd0, bus.result}, {32'd0, first_res});
         check_eq({tag, "_hold_vld"}, {63'd0, bus.out_valid}, 64'd1);
         check_eq({tag, "_hold_rdy"}, {63'd0, bus.in_ready}, 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check_eq({tag, "_drop_vld"}, {63'd0, bus.out_valid}, 64'd0);
      check_eq({tag, "_idle_rdy"}, {63'd0, bus.in_ready}, 64'd1);
   endtask

   initial begin
      int seen;
      clk           = 1'b0;
      rst_n         = 1'b0;
      n_checks      = 0;
      n_fail        = 0;
      bus.in_valid  = 1'b0;
      bus.funct3    = 3'b000;
      bus.rs1       = 32'd0;
      bus.rs2       = 32'd0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check_eq("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
      check_eq("rst_result", {32'd0, bus.result}, 64'd0);
      rst_n = 1'b1;

      run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 5);
      run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
      run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
      run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
      run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
      run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33, 0);
      run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33, 0);
      run_op("divu_z", 3'b101, 32'h00012345, 32'd0,        32'hFFFFFFFF, 1,  2);
      run_op("rem_z",  3'b110, 32'h12345678, 32'd0,        32'h12345678, 1,  0);
      run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
      run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  0);

      // flush while idle blocks acceptance
      bus.funct3   = 3'b101;
      bus.rs1      = 32'd100;
      bus.rs2      = 32'd0;
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      check_eq("idle_flush_busy", {63'd0, bus.busy}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("idle_flush_vld", {63'd0, bus.out_valid}, 64'd0);

      // flush in CALC cycle 10 aborts without presenting a result
      bus.funct3   = 3'b101;
      bus.rs1      = 32'd100;
      bus.rs2      = 32'd7;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check_eq("calc_busy", {63'd0, bus.busy}, 64'd1);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check_eq("flush_busy", {63'd0, bus.busy}, 64'd0);
      check_eq("flush_rdy", {63'd0, bus.in_ready}, 64'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      bus.out_ready = 1'b0;
      check_eq("flush_no_vld", 64'(seen), 64'd0);
      run_op("post_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33, 0);

      // reset at CALC cycle 10 returns every output to its reset value
      bus.funct3   = 3'b000;
      bus.rs1      = 32'd7;
      bus.rs2      = 32'hFFFFFFFD;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_eq("mrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check_eq("mrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check_eq("mrst_busy", {63'd0, bus.busy}, 64'd0);
      check_eq("mrst_result", {32'd0, bus.result}, 64'd0);
      rst_n = 1'b1;
      run_op("post_rst", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
